mem_access_unit: RTL

//  Load/store unit between the EX/MEM pipeline register and the byte-addressed doubleword data memory.
//  - Loads: selects the LB/LH/LW/LD/LBU/LHU/LWU width and applies sign or zero extension.
//  - SD: written in a single cycle.
//  - SB/SH/SW: done as a 2-cycle read-modify-write, because the memory always writes 8 bytes.
//  - Raises stall to the pipeline while a read-modify-write is in flight.

---
 rtl/mem_access_unit.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : mem_access_unit
// Purpose  : Load/store unit between the EX/MEM pipeline register and a
//            byte-addressed doubleword data memory. Loads are extracted and
//            sign/zero extended with one cycle of latency. SD is a single-cycle
//            write. SB/SH/SW use a two-cycle read-modify-write because the
//            memory always writes 8 bytes, and stall is raised while it runs.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
// Ports
//   clk_i          in   1       system clock, rising edge
//   reset_i        in   1       synchronous, active-low reset
//   req_valid_i    in   1       EX/MEM holds a memory instruction
//   req_read_i     in   1       load request
//   req_write_i    in   1       store request (wins over req_read_i)
//   funct3_i       in   3       access size / sign field
//   addr_i         in   ADDR_W  byte address
//   store_data_i   in   XLEN    store value (rs2)
//   stall_o        out  1       hold the pipeline this cycle
//   load_valid_o   out  1       one-cycle pulse, load_data_o is new
//   load_data_o    out  XLEN    extended load result (held until next load)
//   misalign_o     out  1       one-cycle misaligned-access pulse
//   mem_addr_o     out  ADDR_W  memory byte address
//   mem_wdata_o    out  XLEN    memory write data
//   mem_read_o     out  1       memory read enable
//   mem_write_o    out  1       memory write enable
//   mem_rdata_i    in   XLEN    memory read data (combinational)
// Configuration
//   MISALIGN_TRAP_EN : when defined, misaligned h/w/d accesses are trapped
//                      (no memory access, misalign_o pulses). When undefined
//                      every access proceeds and misalign_o stays 0.
// ============================================================================
module mem_access_unit #(
    parameter int XLEN   = 64,
    parameter int ADDR_W = 64
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              req_valid_i,
    input  logic              req_read_i,
    input  logic              req_write_i,
    input  logic [2:0]        funct3_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [XLEN-1:0]   store_data_i,
    output logic              stall_o,
    output logic              load_valid_o,
    output logic [XLEN-1:0]   load_data_o,
    output logic              misalign_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    input  logic [XLEN-1:0]   mem_rdata_i
);

    localparam int NBYTES = XLEN / 8;

    typedef enum logic [0:0] {
        ST_IDLE      = 1'b0,
        ST_RMW_WRITE = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     sdata_q, sdata_d;
    logic [1:0]          size_q, size_d;
    logic [XLEN-1:0]     merge_q, merge_d;
    logic                load_valid_q, load_valid_d;
    logic [XLEN-1:0]     load_data_q, load_data_d;
    logic                misalign_q, misalign_d;

    logic                w_accept;
    logic                w_misaligned;
    logic [3:0]          w_nbytes;
    logic [XLEN-1:0]     w_merged;

    // Width selection and extension of a raw doubleword read.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3,
                                               input logic [XLEN-1:0] d);
        logic [XLEN-1:0] r;
        case (f3)
            3'b000:  r = {{(XLEN-8){d[7]}},   d[7:0]};
            3'b001:  r = {{(XLEN-16){d[15]}}, d[15:0]};
            3'b010:  r = {{(XLEN-32){d[31]}}, d[31:0]};
            3'b100:  r = {{(XLEN-8){1'b0}},   d[7:0]};
            3'b101:  r = {{(XLEN-16){1'b0}},  d[15:0]};
            3'b110:  r = {{(XLEN-32){1'b0}},  d[31:0]};
            default: r = d;                    // 011 ld, 111 treated as ld
        endcase
        return r;
    endfunction

    // Only a request that actually asks for a read or a write is accepted.
    assign w_accept = req_valid_i && (req_read_i || req_write_i);

`ifdef MISALIGN_TRAP_EN
    always_comb begin
        w_misaligned = 1'b0;
        case (funct3_i[1:0])
            2'b01:   w_misaligned = addr_i[0];
            2'b10:   w_misaligned = |addr_i[1:0];
            2'b11:   w_misaligned = |addr_i[2:0];
            default: w_misaligned = 1'b0;
        endcase
    end
`else
    assign w_misaligned = 1'b0;
`endif

    // Low 1/2/4 bytes come from the captured store data, the rest from the
    // doubleword read in the first RMW cycle.
    assign w_nbytes = 4'd1 << size_q;

    always_comb begin
        w_merged = merge_q;
        for (int b = 0; b < NBYTES; b++) begin
            if (b < int'(w_nbytes)) begin
                w_merged[8*b +: 8] = sdata_q[8*b +: 8];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        sdata_d      = sdata_q;
        size_d       = size_q;
        merge_d      = merge_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        misalign_d   = 1'b0;
        stall_o      = 1'b0;
        mem_read_o   = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = addr_i;
        mem_wdata_o  = store_data_i;

        case (state_q)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_misaligned) begin
                        misalign_d = 1'b1;
                    end else if (req_write_i) begin
                        if (funct3_i[1:0] == 2'b11) begin
                            mem_write_o = 1'b1;
                        end else begin
                            mem_read_o = 1'b1;
                            stall_o    = 1'b1;
                            merge_d    = mem_rdata_i;
                            addr_d     = addr_i;
                            sdata_d    = store_data_i;
                            size_d     = funct3_i[1:0];
                            state_d    = ST_RMW_WRITE;
                        end
                    end else begin
                        mem_read_o   = 1'b1;
                        load_valid_d = 1'b1;
                        load_data_d  = extend(funct3_i, mem_rdata_i);
                    end
                end
            end
            ST_RMW_WRITE: begin
                // Inputs are ignored here; the stalled instruction is still
                // presented and must not be accepted a second time.
                mem_write_o = 1'b1;
                mem_addr_o  = addr_q;
                mem_wdata_o = w_merged;
                state_d     = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // Reset blocks memory side effects immediately, including an
        // in-flight RMW write.
        if (!reset_i) begin
            stall_o     = 1'b0;
            mem_read_o  = 1'b0;
            mem_write_o = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            sdata_q      <= '0;
            size_q       <= 2'd0;
            merge_q      <= '0;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            sdata_q      <= sdata_d;
            size_q       <= size_d;
            merge_q      <= merge_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            misalign_q   <= misalign_d;
        end
    end

    assign load_valid_o = load_valid_q;
    assign load_data_o  = load_data_q;
    assign misalign_o   = misalign_q;

endmodule
`default_nettype wire
